// File: rtl/_demux4_buf_pkg.sv
// Shared constants and types for the registered 4-way demultiplexer.
// Holds the default payload width, the channel count and the channel-select type.
package _demux4_buf_pkg;

    localparam int BIT_WIDTH  = 8;
    localparam int DEMUX_WAYS = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // One-hot destination mask for a channel select.
    function automatic logic [DEMUX_WAYS-1:0] sel_decode(input sel_t s);
        logic [DEMUX_WAYS-1:0] mask;
        mask = '0;
        mask[s] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/_demux4_buf_slot.sv
// One-entry valid/ready holding register (module _demux_slot) used per output channel.
// Handshake: a word moves out when valid && ready at a rising edge; the slot is free when
// empty or draining, so a load may land in the same cycle as a drain.
module _demux_slot
    import _demux4_buf_pkg::*;
#(
    parameter int n = BIT_WIDTH
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [n-1:0] din,
    output logic         valid,
    input  logic         ready,
    output logic [n-1:0] dout,
    output logic         free
);

    slot_state_t state;

    // valid is the registered EMPTY/FULL state seen from outside.
    assign valid = (state == SLOT_FULL);
    assign free  = (state == SLOT_EMPTY) || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            dout  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        dout  <= din;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        dout  <= din;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: begin
                    state <= SLOT_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/_demux4_buf.sv
// Registered 4-way demultiplexer: steers one valid/ready stream to one of four slotted channels.
// Optional feature macro: DEMUX4_BROADCAST_EN adds a bcast input that loads all four channels at once.
module _demux4_buf
    import _demux4_buf_pkg::*;
#(
    parameter int n = BIT_WIDTH
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [n-1:0]          in_data,
`ifdef DEMUX4_BROADCAST_EN
    input  logic                  bcast,
`endif
    output logic [DEMUX_WAYS-1:0] out_valid,
    input  logic [DEMUX_WAYS-1:0] out_ready,
    output logic [n-1:0]          out0,
    output logic [n-1:0]          out1,
    output logic [n-1:0]          out2,
    output logic [n-1:0]          out3
);

    sel_t                  dest;
    logic [DEMUX_WAYS-1:0] free;
    logic [DEMUX_WAYS-1:0] dest_mask;
    logic [DEMUX_WAYS-1:0] load;
    logic                  dest_free;
    logic [n-1:0]          dout [DEMUX_WAYS];

    assign dest = sel_t'(sel);

`ifdef DEMUX4_BROADCAST_EN
    // A broadcast needs every channel free and ignores sel.
    assign dest_mask = bcast ? {DEMUX_WAYS{1'b1}} : sel_decode(dest);
    assign dest_free = bcast ? (&free) : free[dest];
`else
    assign dest_mask = sel_decode(dest);
    assign dest_free = free[dest];
`endif

    assign in_ready = !reset && dest_free;
    assign load     = {DEMUX_WAYS{in_valid && in_ready}} & dest_mask;

    for (genvar k = 0; k < DEMUX_WAYS; k++) begin : g_slot
        _demux_slot #(.n(n)) u_slot (
            .clk   (clk),
            .reset (reset),
            .load  (load[k]),
            .din   (in_data),
            .valid (out_valid[k]),
            .ready (out_ready[k]),
            .dout  (dout[k]),
            .free  (free[k])
        );
    end

    assign out0 = dout[0];
    assign out1 = dout[1];
    assign out2 = dout[2];
    assign out3 = dout[3];

endmodule

// File: tb/tb__demux4_buf.sv
// Directed testbench for _demux4_buf with n = 8; broadcast steps build only with DEMUX4_BROADCAST_EN.
module tb__demux4_buf;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
`ifdef DEMUX4_BROADCAST_EN
  logic         bcast;
`endif
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [N-1:0] out0, out1, out2, out3;
  logic [N-1:0] out_arr [4];

  int checks = 0;
  int errors = 0;
  int idx;
  logic fire;
  logic mon_en = 1'b0;
  logic [N-1:0] got_q[$];

  always #5 clk = ~clk;

  _demux4_buf #(.n(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef DEMUX4_BROADCAST_EN
    .bcast     (bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3)
  );

  assign out_arr[0] = out0;
  assign out_arr[1] = out1;
  assign out_arr[2] = out2;
  assign out_arr[3] = out3;

  // channel 1 consumer: records every word it takes
  always @(posedge clk) begin
    if (mon_en && out_valid[1] && out_ready[1]) got_q.push_back(out1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sel = 2'd0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 4'b0000;
`ifdef DEMUX4_BROADCAST_EN
    bcast = 1'b0;
`endif

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_out0", 32'(out0), 32'h00);
    chk("rst_out1", 32'(out1), 32'h00);
    chk("rst_out2", 32'(out2), 32'h00);
    chk("rst_out3", 32'(out3), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    settle();
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // streaming to all four channels, one per cycle
    tick();
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      in_valid = 1'b1;
      in_data = 8'hA0 + 8'(k);
      settle();
      chk("stream_in_ready", 32'(in_ready), 32'h1);
      tick();
      chk("stream_valid", 32'(out_valid), 32'(4'b0001 << k));
      chk("stream_data", 32'(out_arr[k]), 32'(8'hA0 + 8'(k)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle_valid", 32'(out_valid), 32'h0);

    // backpressure on channel 2, channel 0 unaffected
    out_ready = 4'b1010;
    sel = 2'd2; in_data = 8'h55; in_valid = 1'b1;
    settle();
    chk("bp_accept55", 32'(in_ready), 32'h1);
    tick();
    chk("bp_valid55", 32'(out_valid), 32'h4);
    chk("bp_out2_55", 32'(out2), 32'h55);
    sel = 2'd0; in_data = 8'h77;
    settle();
    chk("bp_accept77", 32'(in_ready), 32'h1);
    tick();
    chk("bp_valid77", 32'(out_valid), 32'h5);
    chk("bp_out0_77", 32'(out0), 32'h77);
    sel = 2'd2; in_data = 8'h66;
    settle();
    chk("bp_block66", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold_out2", 32'(out2), 32'h55);
    chk("bp_hold_valid", 32'(out_valid), 32'h5);
    settle();
    chk("bp_block66_again", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold_out2_again", 32'(out2), 32'h55);
    out_ready = 4'b1111;
    settle();
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    tick();
    chk("bp_refill_valid", 32'(out_valid), 32'h4);
    chk("bp_refill_out2", 32'(out2), 32'h66);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", 32'(out_valid), 32'h0);
    chk("bp_keep_out2", 32'(out2), 32'h66);

    // ordering on channel 1 with toggling consumer
    out_ready = 4'b0000;
    got_q.delete();
    mon_en = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && !(idx == 3 && !out_valid[1]); c++) begin
      out_ready[1] = (c % 2 == 0);
      if (idx < 3) begin
        in_valid = 1'b1;
        sel = 2'd1;
        in_data = 8'h10 + 8'(idx);
      end else begin
        in_valid = 1'b0;
      end
      settle();
      fire = in_valid && in_ready;
      tick();
      if (fire) idx++;
    end
    mon_en = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    chk("ord_accepts", 32'(idx), 32'd3);
    chk("ord_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) chk("ord_word", 32'(got_q[i]), 32'(8'h10 + 8'(i)));
    end

    // all four full with no consumer ready
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      in_valid = 1'b1;
      in_data = 8'h40 + 8'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("full_valid", 32'(out_valid), 32'hF);
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      settle();
      chk("full_in_ready", 32'(in_ready), 32'h0);
    end
    // drain all four and refill one in the same cycle
    out_ready = 4'b1111;
    sel = 2'd2; in_data = 8'h99; in_valid = 1'b1;
    settle();
    chk("drain_all_ready", 32'(in_ready), 32'h1);
    tick();
    chk("drain_all_valid", 32'(out_valid), 32'h4);
    chk("drain_all_out2", 32'(out2), 32'h99);
    in_valid = 1'b0;
    tick();
    chk("drain_all_idle", 32'(out_valid), 32'h0);

    // reset mid-operation discards held words
    out_ready = 4'b0000;
    sel = 2'd0; in_data = 8'hC0; in_valid = 1'b1;
    tick();
    sel = 2'd3; in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    chk("mid_rst_pre_valid", 32'(out_valid), 32'h9);
    reset = 1'b1;
    settle();
    chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_out0", 32'(out0), 32'h00);
    chk("mid_rst_out3", 32'(out3), 32'h00);
    reset = 1'b0;
    out_ready = 4'b1111;
    settle();
    chk("mid_rst_after_ready", 32'(in_ready), 32'h1);
    tick();
    chk("mid_rst_no_deliver1", 32'(out_valid), 32'h0);
    tick();
    chk("mid_rst_no_deliver2", 32'(out_valid), 32'h0);

`ifdef DEMUX4_BROADCAST_EN
    // broadcast waits for every channel, then loads all four
    out_ready = 4'b0000;
    bcast = 1'b0; sel = 2'd1; in_data = 8'h31; in_valid = 1'b1;
    tick();
    bcast = 1'b1; sel = 2'd1; in_data = 8'hBC;
    settle();
    chk("bc_blocked", 32'(in_ready), 32'h0);
    tick();
    chk("bc_blocked_valid", 32'(out_valid), 32'h2);
    out_ready = 4'b0010;
    settle();
    chk("bc_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    bcast = 1'b0;
    chk("bc_valid", 32'(out_valid), 32'hF);
    chk("bc_out0", 32'(out0), 32'hBC);
    chk("bc_out1", 32'(out1), 32'hBC);
    chk("bc_out2", 32'(out2), 32'hBC);
    chk("bc_out3", 32'(out3), 32'hBC);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
